ocp2axi_cpl: RTL

- Return-path bridge that builds PCIe completion TLPs and emits them on a 64-bit AXI-Stream master toward the PCIe core TX FIFO.
- Receives one completion context per non-posted request from the request-side bridge.
- Collects the read payload byte-by-byte from the OCP 2.2 response channel (8-bit SData) and packs it behind a 3DW completion header.

---
 rtl/ocp2axi_cpl.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/ocp2axi_cpl.sv
// PCIe completion builder: packs a 3DW Cpl/CplD header plus OCP byte-wide read data onto a 64-bit AXI-Stream master.
// Optional response watchdog enabled by defining OCP2AXI_TIMEOUT_EN.
module ocp2axi_cpl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpl_valid,
   output logic        cpl_ready,
   input  logic        cpl_has_data,
   input  logic [9:0]  cpl_length,
   input  logic [15:0] cpl_req_id,
   input  logic [7:0]  cpl_tag,
   input  logic [6:0]  cpl_lower_addr,
   input  logic [15:0] cpl_completer_id,
   input  logic [1:0]  sresp,
   input  logic [7:0]  sdata,
   output logic        mrespaccept,
   output logic        s_axis_tvalid,
   input  logic        s_axis_tready,
   output logic [63:0] s_axis_tdata,
   output logic [7:0]  s_axis_tkeep,
   output logic        s_axis_tlast,
   output logic        resp_error,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE,
      HDR0,
      HDR1_FILL,
      HDR1_SEND,
      DATA_FILL,
      DATA_SEND
   } state_t;

   localparam logic [1:0] SRESP_NULL = 2'b00;
   localparam logic [1:0] SRESP_DVA  = 2'b01;

   state_t      state_q, state_d;
   logic        cpl_ready_q, cpl_ready_d;
   logic        has_data_q, has_data_d;
   logic [15:0] req_id_q, req_id_d;
   logic [7:0]  tag_q, tag_d;
   logic [6:0]  lower_addr_q, lower_addr_d;
   logic [12:0] rem_q, rem_d;
   logic [3:0]  need_q, need_d;
   logic [2:0]  lane_q, lane_d;
   logic [63:0] data_q, data_d;
   logic [7:0]  keep_q, keep_d;
   logic        last_q, last_d;
   logic        tvalid_q, tvalid_d;
   logic        mrespaccept_q, mrespaccept_d;
   logic        resp_error_q, resp_error_d;
   logic        busy_q, busy_d;

   logic        flush;
   logic        is_fill;
   logic        take;
   logic [7:0]  byte_v;
   logic [2:0]  fmt;
   logic [9:0]  len_field;
   logic [11:0] byte_count;
   logic [31:0] dw0, dw1, dw2;

`ifdef OCP2AXI_TIMEOUT_EN
   logic        flush_q, flush_d;
   logic [31:0] tmo_q, tmo_d;
   assign flush = flush_q;
`else
   logic unused_tmo;
   assign flush      = 1'b0;
   assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

   // Beat 0 is built straight from the context inputs in the handshake cycle
   assign fmt        = cpl_has_data ? 3'b010 : 3'b000;
   assign len_field  = cpl_has_data ? cpl_length : 10'd0;
   assign byte_count = cpl_has_data ? {cpl_length, 2'b00} : 12'd0;
   assign dw0 = {len_field[7:0], 6'b0, len_field[9:8], 8'h00, fmt, 5'b01010};
   assign dw1 = {byte_count[7:0], 3'b000, 1'b0, byte_count[11:8],
                 cpl_completer_id[7:0], cpl_completer_id[15:8]};
   assign dw2 = {1'b0, lower_addr_q, tag_q, req_id_q[7:0], req_id_q[15:8]};

   assign is_fill = (state_q == HDR1_FILL) || (state_q == DATA_FILL);

   always_comb begin
      state_d       = state_q;
      cpl_ready_d   = cpl_ready_q;
      has_data_d    = has_data_q;
      req_id_d      = req_id_q;
      tag_d         = tag_q;
      lower_addr_d  = lower_addr_q;
      rem_d         = rem_q;
      need_d        = need_q;
      lane_d        = lane_q;
      data_d        = data_q;
      keep_d        = keep_q;
      last_d        = last_q;
      tvalid_d      = tvalid_q;
      resp_error_d  = 1'b0;
      take          = 1'b0;
      byte_v        = 8'h00;

      case (state_q)
         IDLE: begin
            cpl_ready_d = 1'b1;
            if (cpl_valid && cpl_ready_q) begin
               cpl_ready_d  = 1'b0;
               has_data_d   = cpl_has_data;
               req_id_d     = cpl_req_id;
               tag_d        = cpl_tag;
               lower_addr_d = cpl_lower_addr;
               if (!cpl_has_data)
                  rem_d = 13'd0;
               else if (cpl_length == 10'd0)
                  rem_d = 13'd4096;
               else
                  rem_d = {1'b0, cpl_length, 2'b00};
               data_d   = {dw1, dw0};
               keep_d   = 8'hFF;
               last_d   = 1'b0;
               tvalid_d = 1'b1;
               state_d  = HDR0;
            end
         end

         HDR0: begin
            if (s_axis_tready) begin
               tvalid_d = 1'b0;
               data_d   = {32'h0, dw2};
               lane_d   = 3'd4;
               need_d   = has_data_q ? 4'd4 : 4'd0;
               keep_d   = has_data_q ? 8'hFF : 8'h0F;
               state_d  = HDR1_FILL;
            end
         end

         HDR1_FILL, DATA_FILL: begin
            take = (need_q != 4'd0) &&
                   (flush || (mrespaccept_q && (sresp != SRESP_NULL)));
            if (take) begin
               // Error responses and watchdog fill still occupy a lane so framing is preserved
               byte_v = (!flush && (sresp == SRESP_DVA)) ? sdata : 8'h00;
               data_d[{lane_q, 3'b000} +: 8] = byte_v;
               lane_d       = lane_q + 3'd1;
               need_d       = need_q - 4'd1;
               rem_d        = rem_q - 13'd1;
               resp_error_d = !flush && sresp[1];
            end
            if (need_d == 4'd0) begin
               tvalid_d = 1'b1;
               last_d   = (rem_d == 13'd0);
               state_d  = (state_q == HDR1_FILL) ? HDR1_SEND : DATA_SEND;
            end
         end

         HDR1_SEND, DATA_SEND: begin
            if (s_axis_tready) begin
               tvalid_d = 1'b0;
               if (rem_q != 13'd0) begin
                  data_d  = '0;
                  lane_d  = 3'd0;
                  state_d = DATA_FILL;
                  if (rem_q >= 13'd8) begin
                     need_d = 4'd8;
                     keep_d = 8'hFF;
                  end else begin
                     need_d = rem_q[3:0];
                     keep_d = 8'h0F;
                  end
               end else begin
                  cpl_ready_d = 1'b1;
                  state_d     = IDLE;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef OCP2AXI_TIMEOUT_EN
      flush_d = flush_q;
      tmo_d   = '0;
      if (state_d == IDLE) begin
         flush_d = 1'b0;
      end else if (is_fill && !flush_q && !take && (need_q != 4'd0)) begin
         tmo_d = tmo_q + 32'd1;
         if (tmo_d >= TIMEOUT_CYCLES) begin
            flush_d      = 1'b1;
            resp_error_d = 1'b1;
            tmo_d        = '0;
         end
      end
      mrespaccept_d = ((state_d == HDR1_FILL) || (state_d == DATA_FILL)) &&
                      (need_d != 4'd0) && !flush_d;
`else
      mrespaccept_d = ((state_d == HDR1_FILL) || (state_d == DATA_FILL)) &&
                      (need_d != 4'd0);
`endif

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cpl_ready_q   <= 1'b0;
         has_data_q    <= 1'b0;
         req_id_q      <= '0;
         tag_q         <= '0;
         lower_addr_q  <= '0;
         rem_q         <= '0;
         need_q        <= '0;
         lane_q        <= '0;
         data_q        <= '0;
         keep_q        <= '0;
         last_q        <= 1'b0;
         tvalid_q      <= 1'b0;
         mrespaccept_q <= 1'b0;
         resp_error_q  <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cpl_ready_q   <= cpl_ready_d;
         has_data_q    <= has_data_d;
         req_id_q      <= req_id_d;
         tag_q         <= tag_d;
         lower_addr_q  <= lower_addr_d;
         rem_q         <= rem_d;
         need_q        <= need_d;
         lane_q        <= lane_d;
         data_q        <= data_d;
         keep_q        <= keep_d;
         last_q        <= last_d;
         tvalid_q      <= tvalid_d;
         mrespaccept_q <= mrespaccept_d;
         resp_error_q  <= resp_error_d;
         busy_q        <= busy_d;
      end
   end

`ifdef OCP2AXI_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flush_q <= 1'b0;
         tmo_q   <= '0;
      end else begin
         flush_q <= flush_d;
         tmo_q   <= tmo_d;
      end
   end
`endif

   // Beat fields are meaningful only while tvalid is high
   assign cpl_ready     = cpl_ready_q;
   assign mrespaccept   = mrespaccept_q;
   assign s_axis_tvalid = tvalid_q;
   assign s_axis_tdata  = tvalid_q ? data_q : 64'h0;
   assign s_axis_tkeep  = tvalid_q ? keep_q : 8'h00;
   assign s_axis_tlast  = tvalid_q & last_q;
   assign resp_error    = resp_error_q;
   assign busy          = busy_q;

endmodule
